// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
//   Resolves conditional branches from the comparator's BrEq/BrLT results,
//   flags mispredicts and illegal funct3 encodings, and maintains a
//   PC-indexed table of 2-bit saturating direction counters plus branch and
//   mispredict statistics.
//
// Parameters
//   ENTRIES  number of prediction counters (power of two, >= 2)
//   CNT_W    width of each statistics counter
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   pred_pc           lookup PC           -> pred_taken (combinational)
//   res_valid         a branch resolves this cycle
//   res_pc            PC of resolving branch (selects counter to update)
//   res_funct3        branch funct3
//   res_pred_taken    direction that was predicted for this branch
//   BrEq, BrLT        comparator results
//   BrUn              comparator unsigned mode
//   res_taken         actual outcome
//   mispredict        legal branch whose outcome differs from prediction
//   illegal_br        funct3 010/011 while res_valid
//   branch_count      legal branches resolved (wraps)
//   mispredict_count  mispredicted branches (wraps)
// ---------------------------------------------------------------------------
module branch_resolver #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pred_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic [2:0]       res_funct3,
    input  logic             res_pred_taken,
    input  logic             BrEq,
    input  logic             BrLT,
    output logic             BrUn,
    output logic             res_taken,
    output logic             mispredict,
    output logic             illegal_br,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [1:0]       r_tbl [ENTRIES];
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mp_cnt;

    logic [IDX_W-1:0] w_pidx;
    logic [IDX_W-1:0] w_ridx;
    logic             w_legal;
    logic             w_dec;
    logic             w_taken;
    logic             w_misp;
    logic             w_upd;
    logic [1:0]       w_cur;
    logic             w_unused;

    // Word-aligned index; upper PC bits are dropped so distant PCs alias.
    assign w_pidx = pred_pc[IDX_W+1:2];
    assign w_ridx = res_pc[IDX_W+1:2];
    assign w_unused = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                        res_pc[31:IDX_W+2], res_pc[1:0]};

    // Lookup reads the registered table: an update in this cycle is not
    // visible until the next one.
    assign pred_taken = r_tbl[w_pidx][1];

    // Unsigned compare only for BLTU/BGEU.
    assign BrUn = res_funct3[2] & res_funct3[1];

    always_comb begin
        w_legal = 1'b1;
        w_dec   = 1'b0;
        case (res_funct3)
            3'b000:  w_dec = BrEq;
            3'b001:  w_dec = ~BrEq;
            3'b100:  w_dec = BrLT;
            3'b101:  w_dec = ~BrLT;
            3'b110:  w_dec = BrLT;
            3'b111:  w_dec = ~BrLT;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_upd      = res_valid & w_legal;
    assign w_taken    = w_upd & w_dec;
    assign w_misp     = w_upd & (w_dec != res_pred_taken);
    assign res_taken  = w_taken;
    assign mispredict = w_misp;
    assign illegal_br = res_valid & ~w_legal;

    assign w_cur = r_tbl[w_ridx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                r_tbl[i] <= 2'b01;
            r_br_cnt <= '0;
            r_mp_cnt <= '0;
        end else if (w_upd) begin
            // Saturating 2-bit counter step.
            if (w_dec) begin
                if (w_cur != 2'b11)
                    r_tbl[w_ridx] <= w_cur + 2'b01;
            end else begin
                if (w_cur != 2'b00)
                    r_tbl[w_ridx] <= w_cur - 2'b01;
            end
            r_br_cnt <= r_br_cnt + CNT_W'(1);
            if (w_misp)
                r_mp_cnt <= r_mp_cnt + CNT_W'(1);
        end
    end

    assign branch_count     = r_br_cnt;
    assign mispredict_count = r_mp_cnt;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic             res_valid;
    logic [31:0]      res_pc;
    logic [2:0]       res_funct3;
    logic             res_pred_taken;
    logic             BrEq, BrLT, BrUn;
    logic             res_taken, mispredict, illegal_br;
    logic [CNT_W-1:0] branch_count, mispredict_count;

    branch_resolver #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc), .res_funct3(res_funct3),
        .res_pred_taken(res_pred_taken), .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn),
        .res_taken(res_taken), .mispredict(mispredict), .illegal_br(illegal_br),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        logic  v;
        logic  taken, misp, ill, brun, pred;
        int    bc, mc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_push   = 0;
    int   n_pop    = 0;

    // Reference model: direction strength 0..3 per entry, plain integer counts.
    int m_tbl [ENTRIES];
    int m_bc, m_mc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    // Architectural branch rule; legal=0 for the two reserved encodings.
    function automatic void decide(input logic [2:0] f3, input logic eq, input logic lt,
                                   output logic legal, output logic tk);
        legal = 1'b1;
        tk    = 1'b0;
        case (int'(f3))
            0: tk = eq;
            1: tk = !eq;
            4: tk = lt;
            5: tk = !lt;
            6: tk = lt;
            7: tk = !lt;
            default: legal = 1'b0;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) m_tbl[i] = 1;
        m_bc = 0;
        m_mc = 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected response, then advance
    // the model to the state after the coming edge.
    task automatic step(input logic r, input logic v, input logic [31:0] pc,
                        input logic [2:0] f3, input logic pt, input logic eq,
                        input logic lt, input logic [31:0] ppc, input string tag);
        exp_t e;
        logic legal, tk;
        @(posedge clk); #1;
        rst = r; res_valid = v; res_pc = pc; res_funct3 = f3;
        res_pred_taken = pt; BrEq = eq; BrLT = lt; pred_pc = ppc;
        decide(f3, eq, lt, legal, tk);
        e.tag   = tag;
        e.v     = v;
        e.taken = v && legal && tk;
        e.misp  = v && legal && (tk != pt);
        e.ill   = v && !legal;
        e.brun  = (f3 == 3'd6) || (f3 == 3'd7);
        e.pred  = (m_tbl[idx_of(ppc)] >= 2);
        e.bc    = m_bc;
        e.mc    = m_mc;
        q.push_back(e);
        n_push++;
        if (r) model_reset();
        else if (v && legal) begin
            if (tk) m_tbl[idx_of(pc)] = (m_tbl[idx_of(pc)] == 3) ? 3 : m_tbl[idx_of(pc)] + 1;
            else    m_tbl[idx_of(pc)] = (m_tbl[idx_of(pc)] == 0) ? 0 : m_tbl[idx_of(pc)] - 1;
            m_bc = (m_bc + 1) % (1 << CNT_W);
            if (tk != pt) m_mc = (m_mc + 1) % (1 << CNT_W);
        end
    endtask

    task automatic idle(input logic [31:0] ppc, input string tag);
        step(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, ppc, tag);
    endtask

    // Monitor: outputs are stable mid-cycle; compare against queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_pop++;
            check({e.tag, ".res_taken"},  int'(res_taken),  int'(e.taken));
            check({e.tag, ".mispredict"}, int'(mispredict), int'(e.misp));
            check({e.tag, ".illegal_br"}, int'(illegal_br), int'(e.ill));
            check({e.tag, ".pred_taken"}, int'(pred_taken), int'(e.pred));
            check({e.tag, ".branch_count"}, int'(branch_count), e.bc);
            check({e.tag, ".mispredict_count"}, int'(mispredict_count), e.mc);
            if (e.v) check({e.tag, ".BrUn"}, int'(BrUn), int'(e.brun));
        end
    end

    initial begin
        logic [2:0] f3;
        rst = 1'b1; res_valid = 1'b0; res_pc = '0; res_funct3 = '0;
        res_pred_taken = 1'b0; BrEq = 1'b0; BrLT = 1'b0; pred_pc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        idle(32'h0,  "reset_pc0");
        idle(32'h4,  "reset_pc4");
        idle(32'h3C, "reset_pc3c");

        // funct3 sweep, all comparator combinations
        for (int f = 0; f < 8; f++)
            for (int c = 0; c < 4; c++) begin
                f3 = 3'(f);
                step(1'b0, 1'b1, 32'(f * 16 + c * 4), f3, c[0], c[0], c[1],
                     32'(f * 16 + c * 4), $sformatf("sweep_f%0d_c%0d", f, c));
            end
        idle(32'h0, "sweep_end");

        // Training at 0x100 from a clean table
        step(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, "train_rst");
        step(1'b0, 1'b1, 32'h100, 3'd0, 1'b0, 1'b1, 1'b0, 32'h100, "train_t1");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 32'h100, 3'd0, 1'b1, 1'b1, 1'b0, 32'h140, "train_sat");
        idle(32'h100, "train_sat_chk");
        // Same-cycle lookup of the updated index sees the old value
        step(1'b0, 1'b1, 32'h100, 3'd0, 1'b1, 1'b0, 1'b0, 32'h100, "train_nt1");
        step(1'b0, 1'b1, 32'h100, 3'd0, 1'b1, 1'b0, 1'b0, 32'h140, "train_nt2");
        idle(32'h100, "train_nt_chk");

        // Reset mid-stream after saturating 0x100
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 32'h100, 3'd1, 1'b0, 1'b0, 1'b0, 32'h100, "mid_train");
        step(1'b1, 1'b1, 32'h100, 3'd0, 1'b0, 1'b1, 1'b0, 32'h100, "mid_rst");
        idle(32'h100, "mid_after");

        // Statistics wrap: 17 legal mispredicted branches
        for (int i = 0; i < 17; i++)
            step(1'b0, 1'b1, 32'h200, 3'd0, 1'b0, 1'b1, 1'b0, 32'h200, "wrap");
        idle(32'h200, "wrap_chk");

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc, ppc;
            pc  = $urandom_range(0, 63) * 4 + ($urandom_range(0, 3) << 12);
            ppc = $urandom_range(0, 1) ? pc : $urandom_range(0, 63) * 4;
            f3  = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0), pc, f3,
                 1'($urandom), 1'($urandom), 1'($urandom), ppc, "rand");
        end
        idle(32'h0, "final");

        @(posedge clk); #1 res_valid = 1'b0;
        repeat (3) @(posedge clk);
        check("scoreboard_drained", n_pop, n_push);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
